// File: rtl/bin_bcd_disp_seq_pkg.sv
// Shared encodings for the sequential binary-to-display-digit converter.
// Optional leading-zero blanking is enabled by BIN_BCD_DISP_SEQ_LEAD_BLANK_EN.
package bin_bcd_disp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEC_SHIFT = 2'd1,
    HEX_LOAD  = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3        = 4'd3;

  localparam logic BASE_DEC = 1'b1;
  localparam logic BASE_HEX = 1'b0;

  // One double-dabble correction on a single BCD digit; the carry out of the digit is dropped.
  function automatic logic [3:0] add3_digit(input logic [3:0] d);
    return (d >= ADD3_THRESH) ? d + ADD3 : d;
  endfunction

endpackage

// File: rtl/bin_bcd_disp_seq_bcd_add3_step.sv
// One combinational double-dabble step: correct every digit, then shift the
// accumulator left by one with the next binary bit entering at the bottom.
module bcd_add3_step
  import bin_bcd_disp_seq_pkg::*;
#(
  parameter int NDIG = 5
) (
  input  logic [4*NDIG-1:0] acc,
  input  logic              bit_in,
  output logic [4*NDIG-1:0] acc_next
);

  logic [4*NDIG-1:0] corr;

  always_comb begin
    corr = '0;
    for (int i = 0; i < NDIG; i++) begin
      corr[4*i +: 4] = add3_digit(acc[4*i +: 4]);
    end
    acc_next = (corr << 1) | {{(4*NDIG-1){1'b0}}, bit_in};
  end

endmodule

// File: rtl/bin_bcd_disp_seq.sv
// Sequential binary-to-display-digit converter with a Start/Done handshake.
// Optional Blank output is enabled by BIN_BCD_DISP_SEQ_LEAD_BLANK_EN.
module bin_bcd_disp_seq
  import bin_bcd_disp_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              Start,
  input  logic              Base,
  input  logic [WIDTH-1:0]  Bin,
  output logic              Busy,
  output logic              Done,
  output logic [4*NDIG-1:0] Digits,
`ifdef BIN_BCD_DISP_SEQ_LEAD_BLANK_EN
  output logic [NDIG-1:0]   Blank,
`endif
  output state_t            DbgState
);

  // Handshake: Start is sampled only while in IDLE; Busy covers the whole
  // conversion and Done is a one-cycle pulse after Busy drops, at which point
  // Digits (and Blank) hold the new result until the next Done.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t            state;
  logic [WIDTH-1:0]  sreg;
  logic [4*NDIG-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [4*NDIG-1:0] acc_next;
  logic [4*NDIG-1:0] hex_val;

  assign DbgState = state;

  bcd_add3_step #(.NDIG(NDIG)) u_step (
    .acc      (acc),
    .bit_in   (sreg[WIDTH-1]),
    .acc_next (acc_next)
  );

  // Hex mode zero-extends the captured value; digits above WIDTH/4 read zero.
  always_comb begin
    hex_val = '0;
    hex_val[WIDTH-1:0] = sreg;
  end

`ifdef BIN_BCD_DISP_SEQ_LEAD_BLANK_EN
  // Digit 0 is never blanked so a zero value still shows a single "0".
  function automatic logic [NDIG-1:0] blank_of(input logic [4*NDIG-1:0] d);
    logic [NDIG-1:0] b;
    logic            zero_above;
    b          = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (d[4*i +: 4] == 4'd0);
      b[i]       = zero_above && (i != 0);
    end
    return b;
  endfunction
`endif

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state  <= IDLE;
      sreg   <= '0;
      acc    <= '0;
      cnt    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Digits <= '0;
`ifdef BIN_BCD_DISP_SEQ_LEAD_BLANK_EN
      Blank  <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            sreg  <= Bin;
            acc   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            // The next state doubles as the captured mode register.
            state <= (Base == BASE_DEC) ? DEC_SHIFT : HEX_LOAD;
          end
        end
        DEC_SHIFT: begin
          acc  <= acc_next;
          sreg <= sreg << 1;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            Digits <= acc_next;
`ifdef BIN_BCD_DISP_SEQ_LEAD_BLANK_EN
            Blank  <= blank_of(acc_next);
`endif
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        HEX_LOAD: begin
          Digits <= hex_val;
`ifdef BIN_BCD_DISP_SEQ_LEAD_BLANK_EN
          Blank  <= blank_of(hex_val);
`endif
          Done   <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
